// File: rtl/mips_pkg.sv
// mips_pkg: shared types and helpers for the MIPS data memory responder.
//   mem_state_t  - responder FSM states (IDLE, BUSY, RESP)
//   byte_lanes_t - one 32-bit word as 4 byte lanes, lane 0 = most significant
//                  byte (byte at the word address, big-endian)
//   MEM_LANES    - number of byte lanes per word
//   addr_error   - request address check (misaligned or out of range)
package mips_pkg;

  localparam int MEM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef logic [7:0] byte_lanes_t [0:MEM_LANES-1];

  // A word request is rejected when it is not word aligned or when it
  // touches address bits above the implemented byte-address range.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input int unsigned addr_width);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'd0);
    out_of_range = ((addr >> addr_width) != 32'd0);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/mem_byte_bank.sv
// mem_byte_bank: word-addressed byte-lane storage for the data memory.
//   clk     - write clock
//   wr_en   - commit all 4 lanes of wr_data to word wr_addr on this edge
//   wr_addr - word index of the store
//   wr_data - store data, lane 0 = byte at the lowest address
//   rd_addr - word index of the load
//   rd_data - combinational read of the 4 lanes at rd_addr
// The array is deliberately not reset: its contents survive a core reset
// and are preloaded from outside.
module mem_byte_bank
  import mips_pkg::*;
#(
  parameter int WORD_BITS = 14
)(
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [WORD_BITS-1:0] wr_addr,
  input  byte_lanes_t          wr_data,
  input  logic [WORD_BITS-1:0] rd_addr,
  output byte_lanes_t          rd_data
);

  localparam int DEPTH = 2 ** WORD_BITS;

  logic [7:0] mem [0:MEM_LANES-1][0:DEPTH-1];

  // Store port: all four lanes of a word commit together.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int l = 0; l < MEM_LANES; l++) begin
        mem[l][wr_addr] <= wr_data[l];
      end
    end
  end

  // Load port: asynchronous read, registered by the responder.
  always_comb begin
    for (int l = 0; l < MEM_LANES; l++) begin
      rd_data[l] = mem[l][rd_addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word load/store responder for the MIPS
// core's data port.
//   clk          - single clock, rising edge
//   rst_b        - asynchronous active-low reset
//   mem_req      - single-cycle request strobe
//   mem_addr     - byte address of the word
//   mem_write_en - 1 = store, 0 = load (sampled with mem_req)
//   mem_data_in  - store data lanes, lane 0 = byte at mem_addr
//   halted       - core halted, blocks new accepts
//   mem_data_out - registered load data (big-endian lanes)
//   mem_ready    - one-cycle completion pulse
//   mem_error    - qualifies mem_ready: request was rejected
// A request is accepted in IDLE or RESP. Good requests complete LATENCY
// edges after the accept edge (counting the accept edge as the first),
// rejected ones complete on the accept edge itself.
module data_mem_responder
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
)(
  input  logic        clk,
  input  logic        rst_b,
  input  logic        mem_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_write_en,
  input  byte_lanes_t mem_data_in,
  input  logic        halted,
  output byte_lanes_t mem_data_out,
  output logic        mem_ready,
  output logic        mem_error
);

  localparam int         WORD_BITS    = ADDR_WIDTH - 2;
  localparam logic [3:0] LAT_RELOAD   = 4'(LATENCY - 1);
  localparam logic       SINGLE_CYCLE = (LATENCY == 1);

  mem_state_t           state_r;
  mem_state_t           state_next_s;
  logic [3:0]           cnt_r;
  logic [WORD_BITS-1:0] addr_r;
  logic                 we_r;
  byte_lanes_t          data_r;

  logic                 accept_s;
  logic                 req_err_s;
  logic                 complete_s;
  logic                 done_we_s;
  logic [WORD_BITS-1:0] done_addr_s;
  byte_lanes_t          done_data_s;
  byte_lanes_t          rd_data_s;
  logic                 bank_we_s;

  // Next-state logic: accept/error decode and the completion edge.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    req_err_s    = 1'b0;
    complete_s   = 1'b0;
    if (((state_r == IDLE) || (state_r == RESP)) && mem_req && !halted) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    req_err_s = accept_s & addr_error(mem_addr, ADDR_WIDTH);
    case (state_r)
      IDLE, RESP: begin
        if (accept_s) begin
          if (req_err_s || SINGLE_CYCLE) begin
            state_next_s = RESP;
          end else begin
            state_next_s = BUSY;
          end
          // With single-cycle latency the accept edge is also the completion edge.
          complete_s = SINGLE_CYCLE & !req_err_s;
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd1) begin
          state_next_s = RESP;
          complete_s   = 1'b1;
        end else begin
          state_next_s = BUSY;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Operands of the completing request: live inputs when it completes on
  // its own accept edge, otherwise the values latched at accept.
  always_comb begin
    if (SINGLE_CYCLE) begin
      done_addr_s = mem_addr[ADDR_WIDTH-1:2];
      done_we_s   = mem_write_en;
      done_data_s = mem_data_in;
    end else begin
      done_addr_s = addr_r;
      done_we_s   = we_r;
      done_data_s = data_r;
    end
  end

  // The bank has no reset, so a store must never commit while reset is held.
  assign bank_we_s = rst_b & complete_s & done_we_s;

  mem_byte_bank #(
    .WORD_BITS (WORD_BITS)
  ) u_bank (
    .clk     (clk),
    .wr_en   (bank_we_s),
    .wr_addr (done_addr_s),
    .wr_data (done_data_s),
    .rd_addr (done_addr_s),
    .rd_data (rd_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Request latch, latency counter and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_r     <= 4'd0;
      addr_r    <= {WORD_BITS{1'b0}};
      we_r      <= 1'b0;
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      for (int l = 0; l < MEM_LANES; l++) begin
        data_r[l]       <= 8'd0;
        mem_data_out[l] <= 8'd0;
      end
    end else begin
      mem_ready <= (state_next_s == RESP);
      mem_error <= req_err_s;
      if (accept_s) begin
        addr_r <= mem_addr[ADDR_WIDTH-1:2];
        we_r   <= mem_write_en;
        for (int l = 0; l < MEM_LANES; l++) begin
          data_r[l] <= mem_data_in[l];
        end
        if (req_err_s || SINGLE_CYCLE) begin
          cnt_r <= 4'd0;
        end else begin
          cnt_r <= LAT_RELOAD;
        end
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      // Load data holds across stores; only loads and rejects update it.
      if (req_err_s) begin
        for (int l = 0; l < MEM_LANES; l++) begin
          mem_data_out[l] <= 8'd0;
        end
      end else if (complete_s && !done_we_s) begin
        for (int l = 0; l < MEM_LANES; l++) begin
          mem_data_out[l] <= rd_data_s[l];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a LATENCY=2 instance runs a
// vector table plus back-to-back and halt sequences; a LATENCY=4 instance
// covers reset during an in-flight store.
module tb_data_mem_responder;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b, rst4_b;
  logic        req2, we2, halt2, rdy2, err2;
  logic [31:0] addr2, wdata2, out2;
  byte_lanes_t din2, dout2;
  logic        req4, we4, halt4, rdy4, err4;
  logic [31:0] addr4, wdata4, out4;
  byte_lanes_t din4, dout4;

  assign din2[0] = wdata2[31:24];
  assign din2[1] = wdata2[23:16];
  assign din2[2] = wdata2[15:8];
  assign din2[3] = wdata2[7:0];
  assign din4[0] = wdata4[31:24];
  assign din4[1] = wdata4[23:16];
  assign din4[2] = wdata4[15:8];
  assign din4[3] = wdata4[7:0];
  assign out2 = {dout2[0], dout2[1], dout2[2], dout2[3]};
  assign out4 = {dout4[0], dout4[1], dout4[2], dout4[3]};

  data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(2)) u_dut (
    .clk(clk), .rst_b(rst_b), .mem_req(req2), .mem_addr(addr2),
    .mem_write_en(we2), .mem_data_in(din2), .halted(halt2),
    .mem_data_out(dout2), .mem_ready(rdy2), .mem_error(err2)
  );

  data_mem_responder #(.ADDR_WIDTH(16), .LATENCY(4)) u_dut4 (
    .clk(clk), .rst_b(rst4_b), .mem_req(req4), .mem_addr(addr4),
    .mem_write_en(we4), .mem_data_in(din4), .halted(halt4),
    .mem_data_out(dout4), .mem_ready(rdy4), .mem_error(err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its ready pulse; lat is the
  // number of falling edges after the accept edge, 0 on timeout.
  task automatic run_req(input bit sel4, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic err, output logic [31:0] data);
    bit got;
    got = 1'b0; lat = 0; err = 1'b0; data = 32'h0;
    @(negedge clk);
    if (sel4) begin
      req4 = 1'b1; we4 = we; addr4 = addr; wdata4 = wdata;
    end else begin
      req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
    end
    @(posedge clk);
    #1;
    req2 = 1'b0;
    req4 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (sel4 ? rdy4 : rdy2) begin
        got  = 1'b1;
        lat  = i;
        err  = sel4 ? err4 : err2;
        data = sel4 ? out4 : out2;
      end
      if (got) break;
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] data;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp [4];
  int          pulse_cyc [4];
  logic [31:0] pulse_dat [4];

  initial begin
    int          lat;
    logic        err;
    logic [31:0] data;
    int          np;
    int          cnt;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 2, 1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 1, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 2, 1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h0001_0000, 32'h1111_1111, 1, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 2, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h0000_0014, 32'h0102_0304, 2, 1'b0, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0000_0015, 32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0000_0000, 2, 1'b0, 32'h0102_0304};
    vecs[10] = '{1'b1, 32'h0000_FFFC, 32'hA5A5_5A5A, 2, 1'b0, 32'h0102_0304};
    vecs[11] = '{1'b0, 32'h0000_FFFC, 32'h0000_0000, 2, 1'b0, 32'hA5A5_5A5A};
    vecs[12] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 2, 1'b0, 32'hCAFE_F00D};
    b2b_addr[0] = 32'h0000_0000; b2b_exp[0] = 32'hCAFE_F00D;
    b2b_addr[1] = 32'h0000_0010; b2b_exp[1] = 32'hDEAD_BEEF;
    b2b_addr[2] = 32'h0000_0014; b2b_exp[2] = 32'h0102_0304;
    b2b_addr[3] = 32'h0000_FFFC; b2b_exp[3] = 32'hA5A5_5A5A;

    rst_b = 1'b0; rst4_b = 1'b0;
    req2 = 1'b0; we2 = 1'b0; halt2 = 1'b0; addr2 = 32'h0; wdata2 = 32'h0;
    req4 = 1'b0; we4 = 1'b0; halt4 = 1'b0; addr4 = 32'h0; wdata4 = 32'h0;
    repeat (3) @(negedge clk);
    rst_b = 1'b1; rst4_b = 1'b1;
    @(negedge clk);
    check32("reset_ready", {31'd0, rdy2}, 32'd0);
    check32("reset_error", {31'd0, err2}, 32'd0);
    check32("reset_data", out2, 32'h0);
    check32("reset4_data", out4, 32'h0);

    // Vector table on the LATENCY=2 instance.
    for (int v = 0; v < 13; v++) begin
      run_req(1'b0, vecs[v].we, vecs[v].addr, vecs[v].wdata, lat, err, data);
      check32($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
      check32($sformatf("vec%0d_error", v), {31'd0, err}, {31'd0, vecs[v].err});
      check32($sformatf("vec%0d_data", v), data, vecs[v].data);
    end

    // halted rising while BUSY does not cancel the in-flight load.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; addr2 = 32'h0000_0014;
    @(posedge clk);
    #1 req2 = 1'b0;
    @(negedge clk);
    check32("halt_busy_no_early_ready", {31'd0, rdy2}, 32'd0);
    halt2 = 1'b1;
    @(negedge clk);
    check32("halt_busy_ready", {31'd0, rdy2}, 32'd1);
    check32("halt_busy_data", out2, 32'h0102_0304);

    // While halted, a held request produces nothing for 10 cycles.
    req2 = 1'b1; addr2 = 32'h0000_0010;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rdy2) cnt++;
    end
    req2 = 1'b0;
    halt2 = 1'b0;
    check32("halted_pulses", cnt, 0);
    check32("halted_data_hold", out2, 32'h0102_0304);
    run_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, err, data);
    check32("unhalt_latency", lat, 2);
    check32("unhalt_data", data, 32'hDEAD_BEEF);

    // Back-to-back loads: mem_req stays high, including through BUSY, and
    // the address advances after each ready pulse.
    np = 0;
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b0; addr2 = b2b_addr[0];
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (rdy2) begin
        if (np < 4) begin
          pulse_cyc[np] = c;
          pulse_dat[np] = out2;
        end
        np++;
        if (np < 4) addr2 = b2b_addr[np];
        else req2 = 1'b0;
      end
    end
    req2 = 1'b0;
    check32("b2b_pulse_count", np, 4);
    check32("b2b_first_latency", pulse_cyc[0], 2);
    for (int k = 1; k < 4; k++) begin
      check32($sformatf("b2b_spacing%0d", k), pulse_cyc[k] - pulse_cyc[k-1], 2);
    end
    for (int k = 0; k < 4; k++) begin
      check32($sformatf("b2b_data%0d", k), pulse_dat[k], b2b_exp[k]);
    end

    // LATENCY=4: reset during an in-flight store discards it.
    run_req(1'b1, 1'b1, 32'h0000_0020, 32'hAABB_CCDD, lat, err, data);
    check32("l4_store_latency", lat, 4);
    run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, err, data);
    check32("l4_load_latency", lat, 4);
    check32("l4_load_data", data, 32'hAABB_CCDD);
    @(negedge clk);
    req4 = 1'b1; we4 = 1'b1; addr4 = 32'h0000_0020; wdata4 = 32'h1234_5678;
    @(posedge clk);
    #1 req4 = 1'b0;
    @(posedge clk);
    #2 rst4_b = 1'b0;
    #1;
    check32("l4_rst_ready", {31'd0, rdy4}, 32'd0);
    check32("l4_rst_error", {31'd0, err4}, 32'd0);
    check32("l4_rst_data", out4, 32'h0);
    repeat (2) @(negedge clk);
    rst4_b = 1'b1;
    run_req(1'b1, 1'b0, 32'h0000_0020, 32'h0, lat, err, data);
    check32("l4_after_rst_latency", lat, 4);
    check32("l4_after_rst_data", data, 32'hAABB_CCDD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Byte-lane data memory responder serving the load/store port of the MIPS core: it accepts word requests on the `mem_addr` / `mem_data_in` / `mem_write_en` interface and returns read words on `mem_data_out`. A fixed, parameterised service latency sets when each request completes. Completion is signalled by a one-cycle `mem_ready` pulse, so a later multi-cycle core can stall on it. The block sits between the core and the testbench-loaded backing store.

## Interface
- `ADDR_WIDTH`, 16, byte-address bits implemented; storage is 2**ADDR_WIDTH bytes.
- `LATENCY`, 2, cycles from accept to response; legal range 1..15.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  single-cycle request strobe.
- `mem_addr`  in  32  byte address of the word.
- `mem_write_en`  in  1  1 = store, 0 = load; sampled with `mem_req`.
- `mem_data_in`  in  8 x [0:3]  store data; lane 0 = bits 31:24.
- `halted`  in  1  core halted; blocks new accepts.
- `mem_data_out`  out  8 x [0:3]  load data, registered; lane 0 = byte at A, lane k = byte at A+k (big-endian).
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_error`  out  1  qualifies `mem_ready`: request was rejected.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- Accept condition: the state is IDLE or RESP, `mem_req`=1, and `halted`=0, sampled on a rising edge. On accept, the block latches the address, the write enable and all 4 data lanes.
- Error check at accept:
  - Error if `mem_addr[1:0]` is not 0 (misaligned).
  - Error if any bit of `mem_addr[31:ADDR_WIDTH]` is set (out of range).
  - An erroring request goes directly to RESP with `mem_error`=1. It writes nothing and loads `mem_data_out` with 0.
- Normal path:
  - If `LATENCY`=1, the accept goes to RESP.
  - Otherwise the accept goes to BUSY with the counter set to `LATENCY`-1. BUSY decrements the counter each edge and moves to RESP when the counter reaches 1.
- Entering RESP is the completion edge:
  - A store commits its 4 bytes to A..A+3 on this edge.
  - A load registers bytes A..A+3 into `mem_data_out` on this edge.
- RESP lasts one cycle. It returns to IDLE, or re-enters the accept path if a new request is accepted in RESP.
- `mem_req` while BUSY, or while `halted`=1, is ignored with no side effects and no error.
- `mem_data_out` holds its value until the next load or error completion. Stores leave it unchanged.
- A load accepted on or after the store's completion edge returns the new data.
- Storage array contents are not affected by reset; the bench preloads them.

## Timing
- Reset values: state IDLE, counter 0, `mem_ready`=0, `mem_error`=0, `mem_data_out`=0 on all lanes.
- Latency: a request accepted at edge E0 produces `mem_ready`=1 in the cycle after edge E0+LATENCY-1.
  - For `LATENCY`=1, that is the cycle immediately after the accepting edge.
  - An erroring request always has 1-cycle latency.
- Throughput: one request per `LATENCY` cycles when each new request is issued during RESP.
- `mem_error` is 0 whenever `mem_ready` is 0.
- Reset asserted mid-operation (BUSY or RESP) aborts immediately. A pending store that has not reached its completion edge is discarded; storage is unchanged.
- `halted` rising while BUSY does not cancel the in-flight request; it completes normally.

## Structure
- `mips_pkg` holds:
  - `mem_state_t` enum: IDLE, BUSY, RESP.
  - `byte_lanes_t` typedef (4 x 8-bit unpacked).
  - `MEM_LANES`=4.
- Sub-module `mem_byte_bank`: the storage array with one 4-lane write port and one 4-lane read port, addressed by word. The top level holds the FSM, counter, error check and output registers.

## Test plan
- Store then load, `LATENCY`=2: store 0xDEADBEEF to 0x0010, then load 0x0010. Each `mem_ready` pulses 2 cycles after its accept. Load returns lanes DE,AD,BE,EF, and byte 0x0013 is EF.
- Misaligned load at 0x0012: `mem_ready`=1 and `mem_error`=1 one cycle after accept; `mem_data_out` is 0; storage unchanged.
- Out-of-range store at 0x00010000 (`ADDR_WIDTH`=16): error pulse; a following load of 0x0000 returns the preloaded value.
- Back-to-back requests: 4 loads, each issued during the previous RESP. Ready pulses are exactly `LATENCY` cycles apart. A `mem_req` asserted while BUSY produces no extra pulse.
- Reset mid-store: accept a store of 0x12345678 to 0x0020 with `LATENCY`=4, then assert `rst_b`=0 at cycle 2. All outputs go to 0 immediately, and a later load of 0x0020 returns the old contents.
- Halt gating: with `halted`=1, a request yields no `mem_ready` for 10 cycles. After `halted`=0, a request completes normally.
